// File: rtl/cache_ctrl_fsm.sv
// Access controller for a 4-way set-associative cache: tag/valid/dirty state, write-back and refill sequencing, LRU tracker drive.
// Optional saturating hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_ctrl_fsm #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  output logic                cpu_ready_o,
  output logic                cpu_hit_o,
  output logic                busy_o,
  input  logic [1:0]          lru_way_i,
  output logic                lru_update_o,
  output logic [INDEX_W-1:0]  lru_set_o,
  output logic [1:0]          lru_access_way_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic                mem_ack_i,
  output logic                fill_pulse_o,
  output logic [15:0]         hit_count_o,
  output logic [15:0]         miss_count_o
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t             state_q;
  logic [TAG_W-1:0]   tag_mem_q [SETS][4];
  logic [3:0]         valid_q   [SETS];
  logic [3:0]         dirty_q   [SETS];
  logic               we_q;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [1:0]         way_q;
  logic               cpu_ready_q, cpu_hit_q, busy_q, lru_update_q;
  logic               mem_req_q, mem_we_q, fill_pulse_q;
  logic [ADDR_W-1:0]  mem_addr_q;

  logic [3:0]         match_s;
  logic               hit_s;
  logic [1:0]         hit_way_s, inv_way_s, victim_way_s;
  logic               victim_dirty_s;
  logic               unused_offset_s;

  assign unused_offset_s = ^cpu_addr_i[OFFSET_W-1:0];

  // Tag compare and victim selection for the latched set
  always_comb begin
    match_s = 4'd0;
    for (int w = 0; w < 4; w++) begin
      match_s[w] = valid_q[idx_q][w] && (tag_mem_q[idx_q][w] == req_tag_q);
    end
    hit_s = |match_s;
    case (match_s)
      4'b0010: hit_way_s = 2'd1;
      4'b0100: hit_way_s = 2'd2;
      4'b1000: hit_way_s = 2'd3;
      default: hit_way_s = 2'd0;
    endcase
    casez (valid_q[idx_q])
      4'b???0: inv_way_s = 2'd0;
      4'b??01: inv_way_s = 2'd1;
      4'b?011: inv_way_s = 2'd2;
      4'b0111: inv_way_s = 2'd3;
      default: inv_way_s = 2'd0;
    endcase
    victim_way_s   = (&valid_q[idx_q]) ? lru_way_i : inv_way_s;
    victim_dirty_s = valid_q[idx_q][victim_way_s] & dirty_q[idx_q][victim_way_s];
  end

  // Access sequencer with cache state arrays and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 4'd0;
        dirty_q[s] <= 4'd0;
        for (int w = 0; w < 4; w++) tag_mem_q[s][w] <= '0;
      end
      we_q         <= 1'b0;
      req_tag_q    <= '0;
      idx_q        <= '0;
      way_q        <= 2'd0;
      cpu_ready_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      busy_q       <= 1'b0;
      lru_update_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      fill_pulse_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req_i) begin
            we_q      <= cpu_we_i;
            req_tag_q <= cpu_addr_i[ADDR_W-1 -: TAG_W];
            idx_q     <= cpu_addr_i[OFFSET_W +: INDEX_W];
            busy_q    <= 1'b1;
            state_q   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (hit_s) begin
            if (we_q) dirty_q[idx_q][hit_way_s] <= 1'b1;
            way_q        <= hit_way_s;
            cpu_ready_q  <= 1'b1;
            cpu_hit_q    <= 1'b1;
            lru_update_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            way_q     <= victim_way_s;
            mem_req_q <= 1'b1;
            if (victim_dirty_s) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= {tag_mem_q[idx_q][victim_way_s], idx_q, {OFFSET_W{1'b0}}};
              state_q    <= S_WRITEBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag_q, idx_q, {OFFSET_W{1'b0}}};
              state_q    <= S_REFILL;
            end
          end
        end
        S_WRITEBACK: begin
          // mem_req stays high: the refill request follows without a gap
          if (mem_ack_i) begin
            dirty_q[idx_q][way_q] <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag_q, idx_q, {OFFSET_W{1'b0}}};
            state_q    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            tag_mem_q[idx_q][way_q] <= req_tag_q;
            valid_q[idx_q][way_q]   <= 1'b1;
            dirty_q[idx_q][way_q]   <= we_q;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            fill_pulse_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          // After a refill the fill cycle comes first, then the completion cycle
          if (fill_pulse_q) begin
            fill_pulse_q <= 1'b0;
            cpu_ready_q  <= 1'b1;
            cpu_hit_q    <= 1'b0;
            lru_update_q <= 1'b1;
          end else begin
            cpu_ready_q  <= 1'b0;
            cpu_hit_q    <= 1'b0;
            lru_update_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ready_o      = cpu_ready_q;
  assign cpu_hit_o        = cpu_hit_q;
  assign busy_o           = busy_q;
  assign lru_update_o     = lru_update_q;
  assign lru_set_o        = idx_q;
  assign lru_access_way_o = way_q;
  assign mem_req_o        = mem_req_q;
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign fill_pulse_o     = fill_pulse_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters, stepped on the completion cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else if (cpu_ready_q) begin
      if (cpu_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = 16'd0;
  assign miss_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Scoreboard bench for cache_ctrl_fsm: a set-level reference model queues expected completions, memory requests and fills.
module tb_cache_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic        cpu_ready, cpu_hit, busy, lru_update, mem_req, mem_we, fill_pulse;
  logic [1:0]  lru_way = 2'd0, lru_access_way;
  logic [3:0]  lru_set;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_count, miss_count;

  cache_ctrl_fsm dut (
    .clk_i(clk), .rst_i(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_ready_o(cpu_ready), .cpu_hit_o(cpu_hit), .busy_o(busy), .lru_way_i(lru_way),
    .lru_update_o(lru_update), .lru_set_o(lru_set), .lru_access_way_o(lru_access_way),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .fill_pulse_o(fill_pulse), .hit_count_o(hit_count), .miss_count_o(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic hit; logic [1:0] way; logic [3:0] set; int rdy; } exp_t;
  typedef struct { logic we; logic [31:0] addr; } mem_t;
  typedef struct { logic [3:0] set; logic [1:0] way; } fill_t;
  exp_t  exp_q[$];
  mem_t  mem_q[$];
  fill_t fill_q[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference cache: tags, valid and dirty per set/way, counts of hits and misses
  bit [23:0] m_tag   [16][4];
  bit        m_valid [16][4];
  bit        m_dirty [16][4];
  int        m_hits = 0, m_miss = 0;

  function automatic void model_reset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = 24'd0; m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
      end
    m_hits = 0; m_miss = 0;
    exp_q.delete(); mem_q.delete(); fill_q.delete();
  endfunction

  function automatic void model_access(input logic [31:0] addr, input logic we,
                                       input logic [1:0] lru, input int issue);
    int        set = int'(addr[7:4]);
    bit [23:0] tag = addr[31:8];
    int        way = -1;
    for (int w = 0; w < 4; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
    if (way >= 0) begin
      if (we) m_dirty[set][way] = 1'b1;
      exp_q.push_back('{1'b1, 2'(way), 4'(set), issue + 2});
      m_hits++;
    end else begin
      for (int w = 3; w >= 0; w--)
        if (!m_valid[set][w]) way = w;
      if (way < 0) way = int'(lru);
      if (m_valid[set][way] && m_dirty[set][way])
        mem_q.push_back('{1'b1, {m_tag[set][way], 4'(set), 4'h0}});
      mem_q.push_back('{1'b0, {tag, 4'(set), 4'h0}});
      fill_q.push_back('{4'(set), 2'(way)});
      m_tag[set][way] = tag; m_valid[set][way] = 1'b1; m_dirty[set][way] = we;
      exp_q.push_back('{1'b0, 2'(way), 4'(set), 0});
      m_miss++;
    end
  endfunction

  // Monitor and memory responder, both acting on the falling edge
  int   force_delay = -1;
  bit   hold_ack = 1'b0;
  int   refill_ack_cyc = 0;
  initial begin
    logic       prev_req = 1'b0, prev_ack = 1'b0, ack;
    logic       cur_we = 1'b0;
    logic [31:0] cur_addr = 32'd0;
    int         delay = 0;
    exp_t e; mem_t m; fill_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
      end else begin
        if (cpu_ready) begin
          if (exp_q.size() == 0) chk("unexpected_ready", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("cpu_hit", 64'(cpu_hit), 64'(e.hit));
            chk("access_way", 64'(lru_access_way), 64'(e.way));
            chk("lru_set", 64'(lru_set), 64'(e.set));
            chk("lru_update", 64'(lru_update), 64'd1);
            chk("ready_latency", 64'(cyc), 64'(e.hit ? e.rdy : refill_ack_cyc + 2));
          end
        end else begin
          chk("no_stray_pulse", 64'({cpu_hit, lru_update}), 64'd0);
        end
        if (fill_pulse) begin
          if (fill_q.size() == 0) chk("unexpected_fill", 64'd1, 64'd0);
          else begin
            f = fill_q.pop_front();
            chk("fill_target", 64'({lru_set, lru_access_way}), 64'({f.set, f.way}));
          end
        end
        if (mem_req && (!prev_req || prev_ack)) begin
          if (mem_q.size() == 0) chk("unexpected_mem_req", 64'(mem_addr), 64'hFFFF_FFFF_FFFF);
          else begin
            m = mem_q.pop_front();
            chk("mem_we", 64'(mem_we), 64'(m.we));
            chk("mem_addr", 64'(mem_addr), 64'(m.addr));
          end
          cur_we = mem_we; cur_addr = mem_addr;
          delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        end else if (mem_req) begin
          chk("mem_stable", 64'({mem_we, mem_addr}), 64'({cur_we, cur_addr}));
        end
        ack = 1'b0;
        if (mem_req && !(hold_ack && !cur_we)) begin
          ack = (delay == 0);
          if (delay > 0) delay--;
        end
        if (ack && !cur_we) refill_ack_cyc = cyc;
        mem_ack = ack;
        prev_req = mem_req; prev_ack = ack;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      cpu_req  = 1'($urandom_range(0, 1));
      cpu_addr = $urandom;
      @(posedge clk); #1;
      n++;
    end
    cpu_req = 1'b0;
    chk("done_timeout", 64'(busy), 64'd0);
  endtask

  task automatic access(input logic [31:0] addr, input logic we, input logic [1:0] lru);
    @(posedge clk); #1;
    lru_way = lru; cpu_we = we; cpu_addr = addr; cpu_req = 1'b1;
    model_access(addr, we, lru, cyc);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_idle();
  endtask

  task automatic chk_stats(input string name);
`ifdef CACHE_STATS_EN
    chk({name, "_hits"}, 64'(hit_count), 64'(m_hits));
    chk({name, "_misses"}, 64'(miss_count), 64'(m_miss));
`else
    chk({name, "_hits"}, 64'(hit_count), 64'd0);
    chk({name, "_misses"}, 64'(miss_count), 64'd0);
`endif
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({cpu_ready, cpu_hit, busy, lru_update, lru_set, lru_access_way,
                              mem_req, mem_we, fill_pulse}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_counts", 64'({hit_count, miss_count}), 64'd0);
    rst = 1'b0;

    force_delay = 3;
    access(32'h0000_0100, 1'b0, 2'd0);            // clean miss into way 0
    force_delay = -1;
    access(32'h0000_0100, 1'b0, 2'd3);            // hit, no memory traffic
    access(32'h0000_0200, 1'b0, 2'd0);
    access(32'h0000_0300, 1'b0, 2'd0);
    access(32'h0000_0400, 1'b0, 2'd0);
    access(32'h0000_0500, 1'b0, 2'd2);            // set full: LRU victim way 2
    access(32'h0000_0100, 1'b1, 2'd1);            // write hit makes way 0 dirty
    access(32'h0000_0600, 1'b0, 2'd0);            // write-back 0x100 then refill 0x600
    chk_stats("stats_directed");

    // Reset while the refill of 0x800 is outstanding
    hold_ack = 1'b1;
    @(posedge clk); #1;
    lru_way = 2'd1; cpu_we = 1'b0; cpu_addr = 32'h0000_0800; cpu_req = 1'b1;
    model_access(32'h0000_0800, 1'b0, 2'd1, cyc);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin @(posedge clk); #1; n++; end
    chk("refill_reached", 64'(mem_req && !mem_we), 64'd1);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid_busy_ready", 64'({busy, cpu_ready}), 64'd0);
    rst = 1'b0;
    hold_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_stats("stats_after_reset");

    access(32'h0000_0100, 1'b0, 2'd0);
    access(32'h0000_0100, 1'b0, 2'd0);
    access(32'h0000_0100, 1'b0, 2'd0);
    access(32'h0000_0700, 1'b0, 2'd0);
    chk_stats("stats_sequence");
    access(32'h0000_0200, 1'b0, 2'd0);            // dropped-by-reset state: misses

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = {24'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      access(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk_stats("stats_final");
    chk("pending_ready", 64'(exp_q.size()), 64'd0);
    chk("pending_mem", 64'(mem_q.size()), 64'd0);
    chk("pending_fill", 64'(fill_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
